// File: rtl/fifo_pkg.sv
// Shared FIFO package: pointer width helper, default almost-full/almost-empty
// offsets and the parameter sanity check reused by FIFO blocks.
package fifo_pkg;

    // Almost-full sits this many entries below the depth by default.
    localparam int unsigned FIFO_AF_OFFSET  = 32'd2;
    // Default almost-empty threshold (count <= this level).
    localparam int unsigned FIFO_AE_DEFAULT = 32'd2;
    // Smallest legal address width.
    localparam int unsigned FIFO_MIN_DEEP   = 32'd1;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned deep);
        return deep + 32'd1;
    endfunction

    // Threshold ordering that every FIFO relies on: AE < AF <= depth.
    function automatic bit levels_ok(input int unsigned ae,
                                     input int unsigned af,
                                     input int unsigned m);
        return (ae < af) && (af <= m);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The array itself is never reset; only the read-data register is.
module fifo_ram #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk_in,
    input  logic          arst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [0:(1<<AW)-1];
    logic [W-1:0] rdata_q;

    // Storage array write port; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-data register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            rdata_q <= {W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with pointer/count/flag tracking around fifo_ram.
// Optional feature macro: FIFO_ERR_FLAGS_EN enables sticky overflow/underflow
// flags cleared by err_clr; without it both flags are tied low.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DEEP   = 3,
    parameter int unsigned AF_LVL = (1 << DEEP) - FIFO_AF_OFFSET,
    parameter int unsigned AE_LVL = FIFO_AE_DEFAULT
) (
    input  logic          clk_in,
    input  logic          arst_n,
    input  logic          w_en,
    input  logic [N-1:0]  data_in,
    input  logic          r_en,
    output logic [N-1:0]  data_o,
    output logic          r_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [DEEP:0] count,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned M  = 32'd1 << DEEP;
    localparam int unsigned PW = ptr_width(DEEP);
    localparam logic [PW-1:0] ONE_P  = PW'(32'd1);
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LVL);

    if (!levels_ok(AE_LVL, AF_LVL, M) || (DEEP < FIFO_MIN_DEEP)) begin : g_param_err
        $error("sync_fifo_mem: need AE_LVL < AF_LVL <= depth and DEEP >= 1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          r_valid_q;
    logic          full_s, empty_s, wr_acc_s, rd_acc_s;

    // Full/empty from the pointers: equal means empty, wrap bits differing means full.
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[DEEP] != rd_ptr_q[DEEP]) &&
                      (wr_ptr_q[DEEP-1:0] == rd_ptr_q[DEEP-1:0]);
    assign wr_acc_s = w_en && !full_s;
    assign rd_acc_s = r_en && !empty_s;

    // Next-state for pointers and occupancy; rejected requests leave state alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_P;
            2'b01:   count_d = count_q - ONE_P;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and read-valid state.
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {PW{1'b0}};
            r_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            r_valid_q <= rd_acc_s;
        end
    end

    fifo_ram #(
        .W  (N),
        .AW (DEEP)
    ) u_ram (
        .clk_in  (clk_in),
        .arst_n  (arst_n),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q[DEEP-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc_s),
        .raddr_i (rd_ptr_q[DEEP-1:0]),
        .rdata_o (data_o)
    );

    assign r_valid      = r_valid_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error next-state: a new error beats a coincident clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_en && full_s) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (r_en && empty_s) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Sticky error flag registers.
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
